enemy_wave_scheduler: RTL

- Sequences the ten-slot enemy Y-coordinate datapath: decides when each slot's plane spawns, recycles it on hit or escape, and raises flying_rate as kills accumulate.
- Also owns lives, kill count and game-over.
- Sits between the game top-level FSM and collision logic on one side, and the y-coordinate counter bank on the other.
- Drives that bank's c_en, des, move_en, flying_rate and active-low reset.

---
 rtl/enemy_pkg.sv | 33 +++
 rtl/enemy_slot_fsm.sv | 69 ++++++
 rtl/enemy_wave_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared encodings and constants for the enemy wave scheduler
// Purpose: top-level and per-slot state encodings, slot count, rate ceiling,
//          and a popcount helper used by the scoring logic.
// Ports:   none (package)
package enemy_pkg;

    localparam int NUM_SLOTS = 10;
    localparam int Y_EDGE    = 120;
    localparam logic [1:0] RATE_MAX = 2'd3;

    typedef enum logic [1:0] {
        TOP_IDLE      = 2'd0,
        TOP_CLEAR     = 2'd1,
        TOP_PLAYING   = 2'd2,
        TOP_GAME_OVER = 2'd3
    } top_state_t;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_ACTIVE  = 2'd1,
        SLOT_RECYCLE = 2'd2
    } slot_state_t;

    function automatic logic [3:0] popcount_slots(input logic [NUM_SLOTS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/enemy_slot_fsm.sv
// rtl/enemy_slot_fsm.sv - lifecycle FSM for one enemy plane slot
// Purpose: tracks FREE -> ACTIVE -> RECYCLE -> FREE for a single slot and
//          reports the kill/escape event that ends an ACTIVE period.
// Ports:   clk, reset (sync, active-high); clear forces FREE; run enables
//          updates; grant spawns a FREE slot; hit/touch_edge/y_home from the
//          datapath; c_en/des decoded from state; free; kill_evt/esc_evt
//          are single-cycle events valid in the cycle the slot leaves ACTIVE.
module enemy_slot_fsm
    import enemy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic grant,
    input  logic hit,
    input  logic touch_edge,
    input  logic y_home,
    output logic c_en,
    output logic des,
    output logic free,
    output logic kill_evt,
    output logic esc_evt
);

    slot_state_t state_q, state_d;

    always_comb begin
        state_d  = state_q;
        kill_evt = 1'b0;
        esc_evt  = 1'b0;
        if (clear) begin
            state_d = SLOT_FREE;
        end else if (run) begin
            case (state_q)
                SLOT_FREE: begin
                    if (grant) state_d = SLOT_ACTIVE;
                end
                SLOT_ACTIVE: begin
                    // A hit landing on the same cycle as the edge touch is a kill.
                    if (hit) begin
                        state_d  = SLOT_RECYCLE;
                        kill_evt = 1'b1;
                    end else if (touch_edge) begin
                        state_d = SLOT_RECYCLE;
                        esc_evt = 1'b1;
                    end
                end
                SLOT_RECYCLE: begin
                    if (y_home) state_d = SLOT_FREE;
                end
                default: state_d = SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    assign c_en = (state_q != SLOT_FREE);
    assign des  = (state_q == SLOT_RECYCLE);
    assign free = (state_q == SLOT_FREE);

endmodule

// File: rtl/enemy_wave_scheduler.sv
// rtl/enemy_wave_scheduler.sv - spawn, recycle and scoring control for ten enemy slots
// Purpose: top game FSM, spawn timer, lowest-free-slot grant, kill/escape
//          scoring, flying_rate levelling and datapath control outputs.
// Ports:   clk, reset (sync, active-high), start; hit/touch_edge/y_home per
//          slot in; c_en/des per slot, move_en, flying_rate, dp_reset_n,
//          lives, kills, game_over out.
module enemy_wave_scheduler
    import enemy_pkg::*;
#(
    parameter int SPAWN_PERIOD    = 25000000,
    parameter int KILLS_PER_LEVEL = 8,
    parameter int LIVES           = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] hit,
    input  logic [NUM_SLOTS-1:0] touch_edge,
    input  logic [NUM_SLOTS-1:0] y_home,
    output logic [NUM_SLOTS-1:0] c_en,
    output logic [NUM_SLOTS-1:0] des,
    output logic                 move_en,
    output logic [1:0]           flying_rate,
    output logic                 dp_reset_n,
    output logic [2:0]           lives,
    output logic [9:0]           kills,
    output logic                 game_over
);

    localparam int TW = $clog2(SPAWN_PERIOD);
    localparam int PW = $clog2(KILLS_PER_LEVEL + NUM_SLOTS) + 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(SPAWN_PERIOD - 1);
    localparam logic [PW-1:0] LEVEL_STEP   = PW'(KILLS_PER_LEVEL);

    top_state_t     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           pending_q, pending_d;
    logic [2:0]     lives_q, lives_d;
    logic [9:0]     kills_q, kills_d;
    logic [PW-1:0]  progress_q, progress_d;
    logic [1:0]     rate_q, rate_d;
    logic           move_en_q, move_en_d;
    logic           game_over_q, game_over_d;
    logic           dp_reset_n_q, dp_reset_n_d;

    logic                 clear;
    logic                 run;
    logic [NUM_SLOTS-1:0] free_slots;
    logic [NUM_SLOTS-1:0] free_neg;
    logic [NUM_SLOTS-1:0] grant;
    logic [NUM_SLOTS-1:0] kill_evt;
    logic [NUM_SLOTS-1:0] esc_evt;
    logic [3:0]           kill_cnt;
    logic [3:0]           esc_cnt;
    logic [10:0]          kill_sum;
    logic [PW-1:0]        progress_sum;
    logic                 expire;

    assign clear = (state_q == TOP_CLEAR);
    // The cycle that leaves PLAYING on lives==0 belongs to the FSM transition,
    // so slot and score updates are suppressed in it.
    assign run   = (state_q == TOP_PLAYING) && (lives_q != 3'd0);

    // Two's-complement trick isolates the lowest set bit: lowest-index FREE slot.
    assign free_neg = -free_slots;
    assign grant    = (pending_q && run) ? (free_slots & free_neg) : '0;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        enemy_slot_fsm u_slot (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .run        (run),
            .grant      (grant[i]),
            .hit        (hit[i]),
            .touch_edge (touch_edge[i]),
            .y_home     (y_home[i]),
            .c_en       (c_en[i]),
            .des        (des[i]),
            .free       (free_slots[i]),
            .kill_evt   (kill_evt[i]),
            .esc_evt    (esc_evt[i])
        );
    end

    assign kill_cnt     = popcount_slots(kill_evt);
    assign esc_cnt      = popcount_slots(esc_evt);
    assign kill_sum     = {1'b0, kills_q} + {7'd0, kill_cnt};
    assign progress_sum = progress_q + PW'(kill_cnt);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        lives_d    = lives_q;
        kills_d    = kills_q;
        progress_d = progress_q;
        rate_d     = rate_q;
        expire     = 1'b0;

        case (state_q)
            TOP_IDLE, TOP_GAME_OVER: begin
                if (start) state_d = TOP_CLEAR;
            end
            TOP_CLEAR: begin
                state_d = TOP_PLAYING;
            end
            TOP_PLAYING: begin
                if (lives_q == 3'd0) state_d = TOP_GAME_OVER;
            end
            default: state_d = TOP_IDLE;
        endcase

        if (clear) begin
            timer_d    = TIMER_RELOAD;
            pending_d  = 1'b0;
            lives_d    = 3'(LIVES);
            kills_d    = '0;
            progress_d = '0;
            rate_d     = '0;
        end else if (run) begin
            if (timer_q == '0) begin
                timer_d = TIMER_RELOAD;
                expire  = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
            // An expiry in the grant cycle re-arms the request immediately.
            pending_d = (pending_q && (grant == '0)) || expire;

            kills_d = kill_sum[10] ? 10'h3FF : kill_sum[9:0];

            progress_d = progress_sum;
            if (progress_sum >= LEVEL_STEP) begin
                progress_d = progress_sum - LEVEL_STEP;
                if (rate_q != RATE_MAX) rate_d = rate_q + 2'd1;
            end

            if ({1'b0, lives_q} <= esc_cnt) lives_d = 3'd0;
            else                            lives_d = lives_q - esc_cnt[2:0];
        end

        move_en_d    = (state_d == TOP_PLAYING);
        game_over_d  = (state_d == TOP_GAME_OVER);
        dp_reset_n_d = (state_d == TOP_PLAYING) || (state_d == TOP_GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= TOP_IDLE;
            timer_q      <= TIMER_RELOAD;
            pending_q    <= 1'b0;
            lives_q      <= 3'(LIVES);
            kills_q      <= '0;
            progress_q   <= '0;
            rate_q       <= '0;
            move_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
            dp_reset_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            lives_q      <= lives_d;
            kills_q      <= kills_d;
            progress_q   <= progress_d;
            rate_q       <= rate_d;
            move_en_q    <= move_en_d;
            game_over_q  <= game_over_d;
            dp_reset_n_q <= dp_reset_n_d;
        end
    end

    assign move_en     = move_en_q;
    assign game_over   = game_over_q;
    assign dp_reset_n  = dp_reset_n_q;
    assign flying_rate = rate_q;
    assign lives       = lives_q;
    assign kills       = kills_q;

endmodule
